// File: rtl/branch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// branch_pc_ctrl
//
// Branch-resolution and PC-update stage sitting between EX and IF of the
// RV32I core. It decodes the conditional-branch condition, computes the
// branch / JAL / JALR target, owns the architectural fetch PC, redirects
// fetch on a taken transfer and squashes the younger IF/ID instructions with
// a counted flush. A transfer to a target that is not 4-byte aligned halts
// the stage with a sticky trap until reset. Two saturating counters track
// resolved and taken conditional branches.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             freezes PC, FSM and counters; suppresses redirect
//   ex_valid          EX stage holds a live instruction
//   ex_branch/jal/jalr instruction class (priority jalr > jal > branch)
//   ex_funct3         conditional-branch condition code
//   ex_pc, ex_imm     PC of the EX instruction, sign-extended immediate
//   ex_rs1            JALR base operand
//   BrEq, BrLT        comparator results
//   BrUn              comparator unsigned-compare select (combinational)
//   pc                registered fetch PC
//   redirect          combinational, taken aligned transfer this cycle
//   flush             registered IF/ID squash
//   trap_misalign     registered, sticky until reset
//   br_cnt, taken_cnt saturating statistics counters
// ---------------------------------------------------------------------------
module branch_pc_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int unsigned     FLUSH_CYCLES = 2,
   parameter int unsigned     CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_jal,
   input  logic             ex_jalr,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic             BrEq,
   input  logic             BrLT,
   output logic             BrUn,
   output logic [XLEN-1:0]  pc,
   output logic             redirect,
   output logic             flush,
   output logic             trap_misalign,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Counter preload: the redirect cycle itself accounts for one flush cycle.
   localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] LSB_CLR    = ~(XLEN'(1));

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              flush_q, flush_d;
   logic              trap_q, trap_d;
   logic [2:0]        fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

   logic              sel_jalr, sel_jal, sel_br;
   logic              cond_taken, f3_valid;
   logic [XLEN-1:0]   sum_pc, sum_rs1, target;
   logic              taken, resolve, misalign;
   logic              count_br, count_taken;

   // Instruction class with jalr > jal > branch priority.
   assign sel_jalr = ex_jalr;
   assign sel_jal  = ex_jal & ~ex_jalr;
   assign sel_br   = ex_branch & ~ex_jal & ~ex_jalr;

   // BLTU/BGEU need an unsigned compare; depends only on funct3.
   assign BrUn = (ex_funct3[2:1] == 2'b11);

   always_comb begin
      cond_taken = 1'b0;
      f3_valid   = 1'b1;
      case (ex_funct3)
         3'b000:  cond_taken = BrEq;
         3'b001:  cond_taken = ~BrEq;
         3'b100:  cond_taken = BrLT;
         3'b101:  cond_taken = ~BrLT;
         3'b110:  cond_taken = BrLT;
         3'b111:  cond_taken = ~BrLT;
         default: f3_valid   = 1'b0;
      endcase
   end

   // Targets wrap modulo 2^XLEN; JALR drops bit 0 of the sum.
   assign sum_pc  = ex_pc + ex_imm;
   assign sum_rs1 = ex_rs1 + ex_imm;
   assign target  = sel_jalr ? (sum_rs1 & LSB_CLR) : sum_pc;

   assign taken    = (sel_br & cond_taken) | sel_jal | sel_jalr;
   assign resolve  = ex_valid & ~stall & (state_q == ST_RUN);
   assign redirect = resolve & taken & ~target[1];
   assign misalign = resolve & taken & target[1];

   // A trapping conditional branch is still counted as resolved and taken.
   assign count_br    = resolve & sel_br & f3_valid;
   assign count_taken = count_br & cond_taken;

   always_comb begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (count_br) begin
         br_cnt_d = sat_inc(br_cnt_q);
      end
      if (count_taken) begin
         taken_cnt_d = sat_inc(taken_cnt_q);
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = flush_q;
      trap_d  = trap_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_RUN: begin
            if (!stall) begin
               if (redirect) begin
                  pc_d    = target;
                  flush_d = 1'b1;
                  fcnt_d  = FLUSH_INIT;
                  // A single-cycle flush needs no FLUSH visit; RUN drops it.
                  state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
               end else if (misalign) begin
                  flush_d = 1'b1;
                  trap_d  = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d    = pc_q + PC_STEP;
                  flush_d = 1'b0;
               end
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               pc_d = pc_q + PC_STEP;
               if (fcnt_q == 3'd0) begin
                  flush_d = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  fcnt_d = fcnt_q - 3'd1;
               end
            end
         end
         ST_HALT: begin
            // Frozen until reset.
         end
         default: begin
            state_d = ST_HALT;
            flush_d = 1'b1;
            trap_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         flush_q     <= 1'b0;
         trap_q      <= 1'b0;
         fcnt_q      <= 3'd0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_q     <= flush_d;
         trap_q      <= trap_d;
         fcnt_q      <= fcnt_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign pc            = pc_q;
   assign flush         = flush_q;
   assign trap_misalign = trap_q;
   assign br_cnt        = br_cnt_q;
   assign taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
module tb_branch_pc_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stall;
   logic             ex_valid, ex_branch, ex_jal, ex_jalr;
   logic [2:0]       ex_funct3;
   logic [XLEN-1:0]  ex_pc, ex_imm, ex_rs1;
   logic             BrEq, BrLT;
   logic             BrUn;
   logic [XLEN-1:0]  pc;
   logic             redirect, flush, trap_misalign;
   logic [CNT_W-1:0] br_cnt, taken_cnt;

   int total = 0;
   int bad   = 0;

   // Expected taken per funct3, indexed by {BrEq,BrLT}.
   logic [3:0] exp_tk [8];
   logic [7:0] exp_brun;

   branch_pc_ctrl #(
      .XLEN(XLEN), .RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
      .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn), .pc(pc), .redirect(redirect),
      .flush(flush), .trap_misalign(trap_misalign),
      .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
      ex_jal    = 1'b0;
      ex_jalr   = 1'b0;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_fl,
                            input logic [3:0] e_br, input logic [3:0] e_tk);
      chk({tag, "_pc"}, pc, e_pc);
      chk({tag, "_flush"}, {31'd0, flush}, {31'd0, e_fl});
      chk({tag, "_br"}, {28'd0, br_cnt}, {28'd0, e_br});
      chk({tag, "_tk"}, {28'd0, taken_cnt}, {28'd0, e_tk});
   endtask

   initial begin
      exp_tk[0] = 4'b1100; exp_tk[1] = 4'b0011; exp_tk[2] = 4'b0000; exp_tk[3] = 4'b0000;
      exp_tk[4] = 4'b1010; exp_tk[5] = 4'b0101; exp_tk[6] = 4'b1010; exp_tk[7] = 4'b0101;
      exp_brun  = 8'b1100_0000;

      rst_n = 1'b0; stall = 1'b0; idle();
      ex_funct3 = 3'd0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0; BrEq = 1'b0; BrLT = 1'b0;

      // Reset, run to pc=0x40, reset again asynchronously.
      repeat (2) tick();
      chk_state("rst0", 32'h0, 1'b0, 4'd0, 4'd0);
      chk("rst0_trap", {31'd0, trap_misalign}, 32'd0);
      rst_n = 1'b1;
      repeat (16) tick();
      chk("run16_pc", pc, 32'h40);
      #20 rst_n = 1'b0;
      #1;
      chk_state("rst1", 32'h0, 1'b0, 4'd0, 4'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("run3_pc", pc, 32'hC);

      // Combinational condition table, all within one clock period.
      ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h100; ex_imm = 32'h20;
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < 4; k++) begin
            ex_funct3 = 3'(f);
            {BrEq, BrLT} = 2'(k);
            #1;
            chk($sformatf("redir_f%0d_k%0d", f, k), {31'd0, redirect}, {31'd0, exp_tk[f][k]});
         end
         chk($sformatf("brun_f%0d", f), {31'd0, BrUn}, {31'd0, exp_brun[f]});
      end
      idle();
      tick();

      // BEQ taken: pc loads target, flush for two cycles.
      ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1; BrLT = 1'b0;
      ex_pc = 32'h100; ex_imm = 32'h20;
      #1;
      chk("beq_brun", {31'd0, BrUn}, 32'd0);
      chk("beq_redir", {31'd0, redirect}, 32'd1);
      tick();
      idle();
      chk_state("beq_e1", 32'h120, 1'b1, 4'd1, 4'd1);
      tick();
      chk_state("beq_e2", 32'h124, 1'b1, 4'd1, 4'd1);
      tick();
      chk_state("beq_e3", 32'h128, 1'b0, 4'd1, 4'd1);

      // BEQ not taken.
      ex_valid = 1'b1; ex_branch = 1'b1; BrEq = 1'b0;
      #1;
      chk("beqn_redir", {31'd0, redirect}, 32'd0);
      tick();
      idle();
      chk_state("beqn", 32'h12C, 1'b0, 4'd2, 4'd1);

      // BGEU taken with negative offset, then stall inside FLUSH.
      ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b111; BrEq = 1'b0; BrLT = 1'b0;
      ex_pc = 32'h200; ex_imm = 32'hFFFF_FFF8;
      #1;
      chk("bgeu_brun", {31'd0, BrUn}, 32'd1);
      chk("bgeu_redir", {31'd0, redirect}, 32'd1);
      tick();
      chk_state("bgeu_e1", 32'h1F8, 1'b1, 4'd3, 4'd2);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stallfl_redir", {31'd0, redirect}, 32'd0);
         tick();
         chk_state("stallfl", 32'h1F8, 1'b1, 4'd3, 4'd2);
      end
      stall = 1'b0;
      idle();
      tick();
      chk_state("bgeu_e2", 32'h1FC, 1'b1, 4'd3, 4'd2);
      tick();
      chk_state("bgeu_e3", 32'h200, 1'b0, 4'd3, 4'd2);

      // Taken branch presented while stalled in RUN.
      stall = 1'b1; ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1;
      ex_pc = 32'h100; ex_imm = 32'h20;
      #1;
      chk("stallrun_redir", {31'd0, redirect}, 32'd0);
      tick();
      chk_state("stallrun", 32'h200, 1'b0, 4'd3, 4'd2);
      stall = 1'b0;

      // BLTU not taken, then reserved funct3 not counted.
      ex_funct3 = 3'b110; BrEq = 1'b0; BrLT = 1'b0;
      #1;
      chk("bltu_brun", {31'd0, BrUn}, 32'd1);
      chk("bltu_redir", {31'd0, redirect}, 32'd0);
      tick();
      chk_state("bltu", 32'h204, 1'b0, 4'd4, 4'd2);
      ex_funct3 = 3'b010; BrEq = 1'b1; BrLT = 1'b1;
      tick();
      chk_state("f3rsv", 32'h208, 1'b0, 4'd4, 4'd2);
      idle();

      // JAL.
      ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h300; ex_imm = 32'h10;
      #1;
      chk("jal_redir", {31'd0, redirect}, 32'd1);
      tick();
      idle();
      chk_state("jal", 32'h310, 1'b1, 4'd4, 4'd2);
      repeat (2) tick();
      chk_state("jal_done", 32'h318, 1'b0, 4'd4, 4'd2);

      // JALR wins over JAL; bit 0 of the sum is cleared.
      ex_valid = 1'b1; ex_jalr = 1'b1; ex_jal = 1'b1; ex_pc = 32'h300;
      ex_rs1 = 32'h401; ex_imm = 32'h10;
      tick();
      idle();
      chk_state("jalr", 32'h410, 1'b1, 4'd4, 4'd2);
      repeat (2) tick();
      chk_state("jalr_done", 32'h418, 1'b0, 4'd4, 4'd2);

      // 20 not-taken branches saturate br_cnt.
      ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b0; BrLT = 1'b0;
      repeat (20) tick();
      chk_state("sat_br", 32'h468, 1'b0, 4'hF, 4'd2);

      // 16 taken branches back to back saturate taken_cnt.
      BrEq = 1'b1; ex_pc = 32'h1000; ex_imm = 32'h0;
      repeat (48) tick();
      idle();
      chk_state("sat_tk", 32'h1008, 1'b0, 4'hF, 4'hF);

      // Misaligned JALR target 0x202 halts with the trap.
      ex_valid = 1'b1; ex_jalr = 1'b1; ex_rs1 = 32'h203; ex_imm = 32'h0;
      #1;
      chk("mis_redir", {31'd0, redirect}, 32'd0);
      tick();
      chk_state("mis", 32'h1008, 1'b1, 4'hF, 4'hF);
      chk("mis_trap", {31'd0, trap_misalign}, 32'd1);
      ex_jalr = 1'b0; ex_branch = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1;
      ex_pc = 32'h100; ex_imm = 32'h20;
      #1;
      chk("halt_redir", {31'd0, redirect}, 32'd0);
      repeat (3) tick();
      chk_state("halt", 32'h1008, 1'b1, 4'hF, 4'hF);
      chk("halt_trap", {31'd0, trap_misalign}, 32'd1);
      idle();

      // Reset out of HALT.
      #20 rst_n = 1'b0;
      #1;
      chk_state("rst_halt", 32'h0, 1'b0, 4'd0, 4'd0);
      chk("rst_halt_trap", {31'd0, trap_misalign}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_pc", pc, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Branch-resolution and PC-update stage that consumes the branch comparator outputs (BrEq, BrLT) and drives the comparator's BrUn select.
- Sits at the EX-to-IF boundary of the RV32I core.
- Decodes the conditional-branch funct3, computes branch/JAL/JALR targets, owns the architectural PC register, redirects fetch, and squashes younger instructions through a counted flush.
- Keeps saturating statistics counters and halts on a misaligned target.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, cycles flush stays high after a redirect (legal 1..7)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; freezes PC, FSM, counters
ex_valid  in  1  EX stage holds a live instruction
ex_branch  in  1  conditional branch (opcode BRANCH)
ex_jal  in  1  JAL
ex_jalr  in  1  JALR
ex_funct3  in  3  branch condition code
ex_pc  in  XLEN  PC of the EX instruction
ex_imm  in  XLEN  sign-extended immediate
ex_rs1  in  XLEN  rs1 operand (JALR base)
BrEq  in  1  comparator equal
BrLT  in  1  comparator less-than
BrUn  out  1  comparator unsigned select
pc  out  XLEN  current fetch PC (registered)
redirect  out  1  combinational; taken control transfer this cycle
flush  out  1  registered squash of IF/ID
trap_misalign  out  1  registered; sticky until reset
br_cnt  out  CNT_W  resolved conditional branches
taken_cnt  out  CNT_W  taken conditional branches

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; flush=0; trap_misalign=0; br_cnt=0; taken_cnt=0.
  - FSM=RUN; flush counter=0.
- BrUn (combinational, independent of state): 1 when ex_funct3 is 110 or 111, else 0.
- cond_taken:
  - 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT.
  - 010/011: not taken, not counted.
- Targets:
  - branch/JAL: ex_pc+ex_imm, mod 2^XLEN.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
- A transfer is "taken" when (ex_branch & cond_taken) | ex_jal | ex_jalr.
- If more than one of ex_branch/ex_jal/ex_jalr is high, priority is jalr > jal > branch.
- "resolve" = ex_valid & !stall & FSM==RUN.
- redirect = resolve & taken & target[1]==0.
- FSM states: RUN, FLUSH, HALT.
  - RUN, no redirect: if !stall, pc <= pc+4.
  - RUN, redirect: pc <= target; flush <= 1; counter <= FLUSH_CYCLES-1; go to FLUSH (or stay in RUN with flush for 1 cycle only if FLUSH_CYCLES==1).
  - RUN, resolve & taken & target[1]==1: pc held; trap_misalign <= 1; flush <= 1; go to HALT.
  - FLUSH: ex_valid ignored; pc <= pc+4 each non-stalled cycle; counter decrements each non-stalled cycle. At counter==0 with !stall: flush <= 0, go to RUN.
  - HALT: pc, counters, and flush=1 frozen until reset; redirect=0.
- Net effect: flush is high for exactly FLUSH_CYCLES non-stalled cycles starting the cycle after the redirect edge; stalled cycles extend it.
- stall=1 in any state: no register changes; redirect=0.
- Counters:
  - br_cnt += 1 on resolve & ex_branch & valid funct3.
  - taken_cnt += 1 on the same condition & cond_taken.
  - Both saturate at all-ones.
  - The misaligned trap case counts as resolved and taken.
- Reset mid-FLUSH or in HALT: immediate return to reset values; no pending redirect survives.
- Latency: redirect-to-pc visible is one clock; flush rises the same edge that pc loads the target.

Test Plan:
- Reset with pc previously 0x40 -> pc=0x0, flush=0, counters 0. Release reset; 3 clocks, no ex_valid -> pc=0xC.
- BEQ: ex_pc=0x100, imm=0x20, funct3=000, BrEq=1 -> BrUn=0, redirect=1; next edge pc=0x120, flush high 2 cycles, br_cnt=1, taken_cnt=1. Same with BrEq=0 -> pc=0x104, no flush.
- BGEU: funct3=111, BrLT=0 -> BrUn=1, taken. BLTU with BrLT=0 -> not taken, br_cnt increments, taken_cnt unchanged.
- JALR: rs1=0x203, imm=0x0 -> target 0x202 (bit0 cleared) -> misaligned: trap_misalign=1, pc holds, flush stays 1. Further ex_valid is ignored until reset.
- Stall: assert stall for 3 cycles during FLUSH -> flush stays high for 2+3 cycles; pc and counters frozen. Redirect during stall=1 -> redirect=0, no pc change.
- Counter saturation: force br_cnt near all-ones with CNT_W=4; 20 resolved branches -> br_cnt=4'hF.
